// File: rtl/message_assembler.sv
// Receive-side frame assembler: packs WORDS input words MSB-first into one message,
// stamps it with the local receive time and hands it to the verifier with a start strobe.
module message_assembler #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned WORDS   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WORD_W-1:0]         in_word,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [WORD_W*WORDS-1:0]   message,
  output logic [31:0]               timestamp,
  output logic                      start,
  output logic                      busy,
  output logic                      frame_error
);

  localparam int unsigned MSG_W = WORD_W * WORDS;
  localparam int unsigned CNT_W = $clog2(WORDS + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DRAIN} state_t;

  state_t             state;
  logic [MSG_W-1:0]   buffer;
  logic [CNT_W-1:0]   count;
  logic [TO_W-1:0]    to_cnt;
  logic [31:0]        time_cnt;
  logic [31:0]        ts_hold;

  logic accept;
  logic last_slot;
  logic timed_out;

  assign accept    = in_valid & in_ready;
  assign last_slot = (count == CNT_W'(WORDS - 1));
  assign timed_out = (to_cnt == TO_W'(TIMEOUT - 1));

  // Buffer shifts left so that the first word of a complete frame ends up in the top slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      buffer      <= '0;
      count       <= '0;
      to_cnt      <= '0;
      time_cnt    <= '0;
      ts_hold     <= '0;
      in_ready    <= 1'b0;
      message     <= '0;
      timestamp   <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      time_cnt    <= time_cnt + 32'd1;
      start       <= 1'b0;
      frame_error <= 1'b0;
      in_ready    <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            buffer <= {buffer[MSG_W-WORD_W-1:0], in_word};
            to_cnt <= '0;
            if (in_last) begin
              frame_error <= 1'b1;
              count       <= '0;
            end else begin
              count <= CNT_W'(1);
              state <= COLLECT;
              busy  <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            buffer <= {buffer[MSG_W-WORD_W-1:0], in_word};
            to_cnt <= '0;
            count  <= count + CNT_W'(1);
            if (last_slot) begin
              if (in_last) begin
                state    <= EMIT;
                ts_hold  <= time_cnt;
                in_ready <= 1'b0;
                busy     <= 1'b0;
              end else begin
                state <= DRAIN;
              end
            end else if (in_last) begin
              frame_error <= 1'b1;
              state       <= IDLE;
              busy        <= 1'b0;
              count       <= '0;
            end
          end else if (timed_out) begin
            frame_error <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            count       <= '0;
            to_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        EMIT: begin
          message   <= buffer;
          timestamp <= ts_hold;
          start     <= 1'b1;
          count     <= '0;
          state     <= IDLE;
        end
        DRAIN: begin
          if (accept) begin
            to_cnt <= '0;
            if (in_last) begin
              frame_error <= 1'b1;
              state       <= IDLE;
              busy        <= 1'b0;
              count       <= '0;
            end
          end else if (timed_out) begin
            frame_error <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            count       <= '0;
            to_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_message_assembler.sv
// Bench for message_assembler: vector table, directed corner sequences and random frames
// checked every cycle against a queue-based frame model.
module tb_message_assembler;

  localparam int unsigned WORDS   = 16;
  localparam int unsigned TIMEOUT = 1024;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] message;
  logic [31:0]  timestamp;
  logic         start;
  logic         busy;
  logic         frame_error;

  message_assembler #(.WORD_W(32), .WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_word(in_word), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .message(message), .timestamp(timestamp), .start(start),
    .busy(busy), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_err = 0;
  int starts[$];

  // Reference model state: words of the frame in progress plus a few flags.
  logic [31:0]  m_q[$];
  bit           m_drop, m_emit, m_ready, m_start, m_err, m_busy;
  int           m_idle;
  logic [511:0] m_msg, m_frame;
  logic [31:0]  m_ts, m_ts_hold, m_tcnt;
  logic [31:0]  force_val;

  typedef struct {
    logic v; logic l; logic [31:0] w;
    logic e_ready; logic e_start; logic e_err; logic e_busy;
  } vec_t;
  vec_t tbl[7];

  task chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [511:0] pack_words(input logic [31:0] q[$]);
    logic [511:0] f = '0;
    foreach (q[i]) f = {f[479:0], q[i]};
    return f;
  endfunction

  function automatic logic [511:0] build(input logic [31:0] base);
    logic [511:0] f = '0;
    for (int i = 0; i < 16; i++) f = {f[479:0], base + 32'(i)};
    return f;
  endfunction

  task model(input logic r, input logic l, input logic [31:0] w, input bit acc);
    if (r) begin
      m_q.delete(); m_drop = 0; m_emit = 0; m_idle = 0; m_ready = 0;
      m_start = 0; m_err = 0; m_busy = 0; m_msg = '0; m_ts = '0; m_tcnt = '0;
    end else begin
      m_start = 0; m_err = 0;
      if (m_emit) begin
        m_msg = m_frame; m_ts = m_ts_hold; m_start = 1; m_emit = 0;
      end else if (acc) begin
        m_idle = 0;
        if (m_drop) begin
          if (l) begin m_err = 1; m_drop = 0; end
        end else begin
          m_q.push_back(w);
          if (l) begin
            if (m_q.size() == WORDS) begin
              m_emit = 1; m_ts_hold = m_tcnt; m_frame = pack_words(m_q);
            end else m_err = 1;
            m_q.delete();
          end else if (m_q.size() == WORDS) begin
            m_drop = 1; m_q.delete();
          end
        end
      end else if (m_drop || m_q.size() > 0) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_err = 1; m_drop = 0; m_q.delete(); m_idle = 0;
        end
      end
      m_busy  = m_drop || (m_q.size() > 0);
      m_ready = !m_emit;
      m_tcnt  = m_tcnt + 32'd1;
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, compare every output after it.
  task step(input logic r, input logic v, input logic l, input logic [31:0] w,
            input bit fen, output bit acc);
    @(negedge clk);
    reset = r; in_valid = v; in_last = l; in_word = w;
    if (fen) begin
      force dut.time_cnt = force_val;
      release dut.time_cnt;
      m_tcnt = force_val;
    end
    acc = !r && v && m_ready;
    @(posedge clk);
    model(r, l, w, acc);
    cyc++;
    #1;
    chk("in_ready", 512'(in_ready), 512'(m_ready));
    chk("start", 512'(start), 512'(m_start));
    chk("frame_error", 512'(frame_error), 512'(m_err));
    chk("busy", 512'(busy), 512'(m_busy));
    chk("message", message, m_msg);
    chk("timestamp", 512'(timestamp), 512'(m_ts));
    if (start) starts.push_back(cyc);
    if (frame_error) n_err++;
  endtask

  task idle(input int n, input bit rnd_last);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd_last ? 1'($urandom) : 1'b0, $urandom, 1'b0, a);
  endtask

  task send(input logic [31:0] w, input logic l);
    bit a;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, l, w, 1'b0, a);
      if (a) return;
    end
    tests++; fails++;
    $display("FAIL send_bound: word %0h not accepted within 4 cycles, required acceptance", w);
  endtask

  task send_frame(input logic [31:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) send(base + 32'(i), i == last_at);
  endtask

  initial begin
    bit a;
    int e0, s0;
    logic [511:0] saved;

    tbl[0] = '{1'b1, 1'b0, 32'hA0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 32'hA1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 32'hA4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 32'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 32'hA6, 1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_word = '0;
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, a);
    chk("reset_in_ready", 512'(in_ready), 512'(0));
    chk("reset_message", message, '0);
    idle(1, 1'b0);
    chk("ready_after_reset", 512'(in_ready), 512'(1));

    // Vector table: short frames and in_last without in_valid.
    for (int i = 0; i < 7; i++) begin
      step(1'b0, tbl[i].v, tbl[i].l, tbl[i].w, 1'b0, a);
      chk($sformatf("tbl%0d_ready", i), 512'(in_ready), 512'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_start", i), 512'(start), 512'(tbl[i].e_start));
      chk($sformatf("tbl%0d_err", i), 512'(frame_error), 512'(tbl[i].e_err));
      chk($sformatf("tbl%0d_busy", i), 512'(busy), 512'(tbl[i].e_busy));
    end

    // Frame 0..15, no gaps.
    e0 = n_err; s0 = starts.size();
    send_frame(32'h0, 16, 15);
    idle(2, 1'b0);
    chk("f0_top_word", 512'(message[511:480]), 512'(0));
    chk("f0_low_word", 512'(message[31:0]), 512'(32'hF));
    chk("f0_starts", 512'(starts.size() - s0), 512'(1));
    chk("f0_no_err", 512'(n_err - e0), 512'(0));

    // Back-to-back frames with valid held high.
    s0 = starts.size();
    send_frame(32'h100, 16, 15);
    send_frame(32'h200, 16, 15);
    idle(2, 1'b0);
    chk("b2b_starts", 512'(starts.size() - s0), 512'(2));
    if (starts.size() >= 2) chk("b2b_gap", 512'(starts[$] - starts[$-1]), 512'(17));
    chk("b2b_msg", message, build(32'h200));

    // Short frame at word 5.
    saved = message; e0 = n_err; s0 = starts.size();
    send_frame(32'h300, 6, 5);
    idle(2, 1'b0);
    chk("short_err", 512'(n_err - e0), 512'(1));
    chk("short_no_start", 512'(starts.size() - s0), 512'(0));
    chk("short_msg_kept", message, saved);
    send_frame(32'h400, 16, 15);
    idle(2, 1'b0);
    chk("after_short_msg", message, build(32'h400));

    // 20-word frame drains to its last word.
    e0 = n_err; s0 = starts.size();
    send_frame(32'h500, 16, -1);
    chk("drain_busy", 512'(busy), 512'(1));
    send_frame(32'h510, 4, 3);
    idle(2, 1'b0);
    chk("long_err", 512'(n_err - e0), 512'(1));
    chk("long_no_start", 512'(starts.size() - s0), 512'(0));

    // Stall of TIMEOUT-1 survives; stall of TIMEOUT abandons the frame.
    e0 = n_err;
    send_frame(32'h600, 3, -1);
    idle(TIMEOUT - 1, 1'b0);
    send_frame(32'h603, 13, 12);
    idle(2, 1'b0);
    chk("stall1023_msg", message, build(32'h600));
    chk("stall1023_err", 512'(n_err - e0), 512'(0));
    send_frame(32'h700, 3, -1);
    idle(TIMEOUT, 1'b0);
    idle(1, 1'b0);
    chk("stall1024_err", 512'(n_err - e0), 512'(1));
    chk("stall1024_busy", 512'(busy), 512'(0));
    send_frame(32'h800, 16, 15);
    idle(2, 1'b0);
    chk("after_timeout_msg", message, build(32'h800));

    // Reset after 8 words.
    e0 = n_err;
    send_frame(32'h900, 8, -1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, a);
    chk("midreset_msg", message, '0);
    chk("midreset_busy", 512'(busy), 512'(0));
    idle(1, 1'b0);
    chk("midreset_no_err", 512'(n_err - e0), 512'(0));
    send_frame(32'hA00, 16, 15);
    idle(2, 1'b0);
    chk("after_reset_msg", message, build(32'hA00));

    // Counter wrap: last word lands on the cycle the counter reads 0.
    force_val = 32'hFFFF_FFF0;
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, a);
    send_frame(32'hB00, 16, 15);
    idle(2, 1'b0);
    chk("wrap_timestamp", 512'(timestamp), 512'(0));

    // Random frames of varied length with random gaps.
    for (int f = 0; f < 40; f++) begin
      int len, sel;
      logic [31:0] base;
      sel  = int'($urandom % 8);
      base = $urandom;
      len  = (sel < 5) ? 16 : (sel == 5) ? int'($urandom_range(1, 15)) : int'($urandom_range(17, 20));
      for (int i = 0; i < len; i++) begin
        send(base + 32'(i), i == len - 1);
        if (i != len - 1) idle(int'($urandom % 3), 1'b1);
        if ($urandom % 200 == 0) idle(TIMEOUT + 2, 1'b0);
      end
      idle(int'($urandom % 3), 1'b1);
    end
    idle(3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/message_assembler.md
Name: message_assembler

Overview:
- Receive-side stage directly upstream of the message verifier.
- Accepts the incoming frame as a stream of 32-bit words over a valid/ready handshake and assembles 16 words into one 512-bit message, MSB-first.
- Captures the local receive timestamp from a free-running cycle counter when a frame completes.
- Presents message and timestamp to the verifier with a one-cycle start strobe. Malformed or stalled frames are discarded and flagged, never forwarded.

Parameters:
- WORD_W, 32, width of one input word.
- WORDS, 16, words per frame (WORD_W*WORDS = 512).
- TIMEOUT, 1024, maximum idle cycles between accepted words inside a frame before the frame is abandoned.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_word  input  32  frame word.
- in_valid  input  1  in_word valid.
- in_last  input  1  marks final word of a frame; qualified by in_valid.
- in_ready  output  1  word accepted when in_valid & in_ready.
- message  output  512  assembled frame; word 0 in [511:480], word 15 in [31:0].
- timestamp  output  32  receive-time counter value captured with the frame.
- start  output  1  one-cycle strobe: message/timestamp are newly valid.
- busy  output  1  high while a frame is partially collected (COLLECT or DRAIN).
- frame_error  output  1  one-cycle pulse on a discarded frame.

Behaviour:
- Reset values: in_ready=0 during reset and 1 the cycle after; message=0, timestamp=0, start=0, busy=0, frame_error=0; time counter=0; state=IDLE; word count=0; timeout counter=0.
- Clocking and reset: one clock, clk; reset is synchronous and active-high. Reset mid-frame discards all partial data, with no error pulse.
- Time counter: 32-bit, increments every cycle, wraps 0xFFFFFFFF -> 0.
- Shift buffer: an internal 512-bit buffer, separate from message, so that message stays stable until the next good frame.
- State IDLE:
  - in_ready=1.
  - An accepted word is written to word slot 0, count=1, then go to COLLECT.
  - If that word has in_last=1, the frame is a short frame: frame_error pulse next cycle and stay in IDLE.
- State COLLECT:
  - in_ready=1, busy=1.
  - Each accepted word fills slot count, count++, and the timeout counter clears.
  - Accepted word with count==WORDS-1 and in_last=1: go to EMIT.
  - Accepted word with count==WORDS-1 and in_last=0: frame too long; go to DRAIN.
  - Accepted word with count<WORDS-1 and in_last=1: short frame; frame_error, go to IDLE.
  - No word accepted: timeout counter++. When it reaches TIMEOUT, frame_error, go to IDLE, count=0.
- State EMIT (exactly 1 cycle):
  - in_ready=0.
  - message <= buffer; timestamp <= time counter value of the cycle the final word was accepted; start=1 for this cycle only.
  - Then go to IDLE.
  - Latency: start asserts the cycle after the last word handshake. Back-to-back frames therefore cost one bubble cycle.
- State DRAIN:
  - in_ready=1, busy=1; words are discarded.
  - On an accepted word with in_last=1: frame_error, go to IDLE.
  - The timeout also applies here; on expiry: frame_error, go to IDLE.
- frame_error: registered, exactly one cycle per discarded frame; never coincident with start.
- Outputs message and timestamp change only in EMIT or on reset.
- in_last without in_valid is ignored.

Test Plan:
- Reset, then 16 words 0x00000000..0x0000000F with no gaps and in_last on word 15.
  - Response: start pulses 1 cycle after the 16th handshake; message[511:480]=0, message[31:0]=0xF; timestamp = counter at last handshake; frame_error stays 0.
- Two back-to-back frames with valid held high.
  - Response: in_ready=0 for exactly the EMIT cycle; two start pulses 17 cycles apart; the second message does not corrupt the first until its own EMIT.
- in_last on word 5.
  - Response: frame_error pulses once; no start; message keeps its previous value; the next good frame is assembled correctly.
- 20 words with in_last on word 19.
  - Response: DRAIN entered after word 16; frame_error pulses once after word 19; no start.
- Mid-frame stall:
  - After 3 words, stall 1023 cycles, then resume: frame completes normally.
  - Stall 1024 cycles instead: frame_error and return to IDLE; the next word starts a new frame at slot 0.
- Assert reset for 1 cycle after 8 words.
  - Response: all outputs return to reset values; no frame_error; a new full frame is assembled correctly afterwards.
- Force the time counter near 0xFFFFFFFF.
  - Response: the captured timestamp wraps to 0x00000000 correctly.
